// File: rtl/fpadd_arb_pkg.sv
// Shared types and helpers for the FP adder arbiter.
// Arbitration mode is selected by FPADD_ARB_RR_EN (defined: round-robin, else fixed priority).
package fpadd_arb_pkg;

    localparam int unsigned FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    // Index of the set bit in a one-hot vector; zero when no bit is set.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fpadd_rr_pick.sv
// Combinational N-way request picker producing a one-hot grant.
// FPADD_ARB_RR_EN defined: search starts at ptr and wraps; undefined: lowest index wins.
module fpadd_rr_pick
    import fpadd_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt
);

`ifdef FPADD_ARB_RR_EN
    always_comb begin
        logic            found;
        logic [IdxW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IdxW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // The pointer only matters for round-robin.
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one FP adder between N requesters; tags each issue and routes the sum back to its owner.
// FPADD_ARB_RR_EN selects round-robin arbitration (default build: fixed priority).
module fpadd_arbiter
    import fpadd_arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N*FP_W-1:0] req_a,
    input  logic [N*FP_W-1:0] req_b,
    output logic [N-1:0]      req_ready,
    output logic [FP_W-1:0]   add_a,
    output logic [FP_W-1:0]   add_b,
    input  logic [FP_W-1:0]   add_sum,
    output logic [N-1:0]      rsp_valid,
    output logic [FP_W-1:0]   rsp_sum,
    output logic              busy
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = $clog2(LAT + 2);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("fpadd_arbiter: N must be in 2..16");
    end
    if (LAT > 15) begin : g_bad_lat
        $error("fpadd_arbiter: LAT must be at most 15");
    end

    logic [N-1:0]    req_live;
    logic [N-1:0]    gnt;
    logic            xfer;
    logic [IdxW-1:0] ptr;

    // Requests are masked during reset so no grant can escape.
    assign req_live = rst ? '0 : req_valid;
    assign xfer     = |gnt;

    fpadd_rr_pick #(
        .N(N)
    ) u_pick (
        .req(req_live),
        .ptr(ptr),
        .gnt(gnt)
    );

`ifdef FPADD_ARB_RR_EN
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [15:0]     gnt_wide;
    logic [3:0]      gnt_idx;

    always_comb begin
        gnt_wide        = '0;
        gnt_wide[N-1:0] = gnt;
        gnt_idx         = onehot_to_idx(gnt_wide);
        ptr_d           = ptr_q;
        if (xfer) begin
            ptr_d = (32'(gnt_idx) == N - 1) ? '0 : IdxW'(gnt_idx + 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    fp32_t sel_a, sel_b;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*FP_W +: FP_W];
                sel_b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    fp32_t           add_a_q, add_b_q, rsp_sum_q;
    logic [N-1:0]    tag_q [LAT+1];
    logic [LAT:0]    tag_vld_q;
    logic [N-1:0]    rsp_valid_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_fire;

    // The tag leaves the pipe in the cycle add_sum is valid for that issue.
    assign rsp_fire = tag_vld_q[LAT];

    always_comb begin
        cnt_d = cnt_q;
        case ({xfer, rsp_fire})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            cnt_q       <= '0;
            for (int unsigned k = 0; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (xfer) begin
                add_a_q <= sel_a;
                add_b_q <= sel_b;
            end
            tag_q[0]     <= gnt;
            tag_vld_q[0] <= xfer;
            for (int unsigned k = 1; k <= LAT; k++) begin
                tag_q[k]     <= tag_q[k-1];
                tag_vld_q[k] <= tag_vld_q[k-1];
            end
            rsp_valid_q <= rsp_fire ? tag_q[LAT] : '0;
            if (rsp_fire) begin
                rsp_sum_q <= add_sum;
            end
            cnt_q <= cnt_d;
        end
    end

    assign req_ready = gnt;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter: one LAT=0 and one LAT=3 instance, N=4, with a bench-side adder.
module tb_fpadd_arbiter;

`ifdef FPADD_ARB_RR_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0, rst3;
    logic [3:0]   rv0, rv3, rdy0, rdy3, rspv0, rspv3;
    logic [127:0] ra0, rb0, ra3, rb3;
    logic [31:0]  aa0, ab0, sum0, rs0, aa3, ab3, sum3, rs3;
    logic         busy0, busy3;
    logic [31:0]  p1, p2, p3;

    int checks = 0;
    int failures = 0;

    // Bench adder: known IEEE-754 sums; anything else returns a recognisable non-sum.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3FC00000, 32'h40200000}: return 32'h40800000;
            {32'h40A00000, 32'h40400000}: return 32'h41000000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40400000, 32'h3F800000}: return 32'h40800000;
            default:                      return a ^ b;
        endcase
    endfunction

    assign sum0 = fp_model(aa0, ab0);

    always @(posedge clk) begin
        p1 <= fp_model(aa3, ab3);
        p2 <= p1;
        p3 <= p2;
    end
    assign sum3 = p3;

    fpadd_arbiter #(.N(4), .LAT(0)) dut0 (
        .clk(clk), .rst(rst0), .req_valid(rv0), .req_a(ra0), .req_b(rb0), .req_ready(rdy0),
        .add_a(aa0), .add_b(ab0), .add_sum(sum0), .rsp_valid(rspv0), .rsp_sum(rs0),
        .busy(busy0)
    );

    fpadd_arbiter #(.N(4), .LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(rv3), .req_a(ra3), .req_b(rb3), .req_ready(rdy3),
        .add_a(aa3), .add_b(ab3), .add_sum(sum3), .rsp_valid(rspv3), .rsp_sum(rs3),
        .busy(busy3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One live slot, the others filled with distinct junk so a wrong mux select shows up.
    function automatic logic [127:0] pack1(input int slot, input logic [31:0] v);
        logic [127:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i*32 +: 32] = (i == slot) ? v : (32'hBAD0_0000 + 32'(i));
        end
        return p;
    endfunction

    typedef struct {
        logic [3:0]   rv;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   ready;
        logic [3:0]   rsp;
        logic [31:0]  sum;
        logic [31:0]  aa;
        logic [31:0]  ab;
        logic         busy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] rv, input int slot, input logic [31:0] av,
                                input logic [31:0] bv, input logic [3:0] ready,
                                input logic [3:0] rsp, input logic [31:0] sum,
                                input logic [31:0] aa, input logic [31:0] ab, input logic busy);
        vec_t v;
        v.rv    = rv;
        v.a     = pack1(slot, av);
        v.b     = pack1(slot, bv);
        v.ready = ready;
        v.rsp   = rsp;
        v.sum   = sum;
        v.aa    = aa;
        v.ab    = ab;
        v.busy  = busy;
        return v;
    endfunction

    vec_t        vecs [11];
    logic [31:0] sa [4], sb [4], ss [4];
    logic [3:0]  e2 [6];
    logic [3:0]  ptag [5];
    logic [31:0] pa [5], pb [5], psum [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // LAT=0 single-request and back-to-back vectors, one row per cycle.
        vecs[0]  = mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1'b0);
        vecs[1]  = mk(4'h4, 2, 32'h3F800000, 32'h40000000, 4'h4, 4'h0, 0, 0, 0, 1'b0);
        vecs[2]  = mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 32'h3F800000, 32'h40000000, 1'b1);
        vecs[3]  = mk(4'h0, 0, 0, 0, 4'h0, 4'h4, 32'h40400000, 32'h3F800000, 32'h40000000,
                      1'b0);
        vecs[4]  = mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 32'h3F800000, 32'h40000000, 1'b0);
        vecs[5]  = mk(4'h1, 0, 32'h3FC00000, 32'h40200000, 4'h1, 4'h0, 0, 32'h3F800000,
                      32'h40000000, 1'b0);
        vecs[6]  = mk(4'h8, 3, 32'h40A00000, 32'h40400000, 4'h8, 4'h0, 0, 32'h3FC00000,
                      32'h40200000, 1'b1);
        vecs[7]  = mk(4'h2, 1, 32'h3F800000, 32'h3F800000, 4'h2, 4'h1, 32'h40800000,
                      32'h40A00000, 32'h40400000, 1'b1);
        vecs[8]  = mk(4'h0, 0, 0, 0, 4'h0, 4'h8, 32'h41000000, 32'h3F800000, 32'h3F800000,
                      1'b1);
        vecs[9]  = mk(4'h0, 0, 0, 0, 4'h0, 4'h2, 32'h40000000, 32'h3F800000, 32'h3F800000,
                      1'b0);
        vecs[10] = mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 32'h3F800000, 32'h3F800000, 1'b0);

        sa = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h40A00000};
        sb = '{32'h40000000, 32'h40200000, 32'h3F800000, 32'h40400000};
        ss = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h41000000};
        if (RrMode) e2 = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h8, 4'h8};
        else        e2 = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8};
        ptag = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1};
        pa   = '{32'h3FC00000, 32'h3F800000, 32'h40A00000, 32'h3F800000, 32'h40400000};
        pb   = '{32'h40200000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h3F800000};
        psum = '{32'h40800000, 32'h40400000, 32'h41000000, 32'h40000000, 32'h40800000};

        // Reset held 3 cycles with every requester valid.
        rst0 = 1'b1; rst3 = 1'b1; rv0 = 4'hF; rv3 = 4'hF;
        ra0 = pack1(0, 32'h1); rb0 = pack1(0, 32'h2); ra3 = ra0; rb3 = rb0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rst_ready0_c%0d", c), 32'(rdy0), 0);
            chk($sformatf("rst_ready3_c%0d", c), 32'(rdy3), 0);
            chk($sformatf("rst_rsp0_c%0d", c), 32'(rspv0), 0);
            chk($sformatf("rst_rsp3_c%0d", c), 32'(rspv3), 0);
            chk($sformatf("rst_busy0_c%0d", c), 32'(busy0), 0);
            chk($sformatf("rst_busy3_c%0d", c), 32'(busy3), 0);
        end
        chk("rst_add_a0", aa0, 0);
        chk("rst_add_b3", ab3, 0);
        chk("rst_rsp_sum0", rs0, 0);
        next_cycle();
        rst0 = 1'b0; rst3 = 1'b0; rv0 = 4'h0; rv3 = 4'h0;

        // Table-driven LAT=0 vectors.
        for (int i = 0; i < 11; i++) begin
            rv0 = vecs[i].rv; ra0 = vecs[i].a; rb0 = vecs[i].b;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(rdy0), 32'(vecs[i].ready));
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rspv0), 32'(vecs[i].rsp));
            chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_add_a", i), aa0, vecs[i].aa);
            chk($sformatf("vec%0d_add_b", i), ab0, vecs[i].ab);
            if (vecs[i].rsp != 4'h0) chk($sformatf("vec%0d_rsp_sum", i), rs0, vecs[i].sum);
            next_cycle();
        end

        // All four requesters contending continuously from a fresh reset.
        for (int i = 0; i < 4; i++) begin
            ra0[i*32 +: 32] = sa[i];
            rb0[i*32 +: 32] = sb[i];
        end
        rst0 = 1'b1; rv0 = 4'hF;
        next_cycle();
        next_cycle();
        rst0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            int gi, ri;
            rv0 = (k < 10) ? 4'hF : 4'h0;
            gi  = RrMode ? (k % 4) : 0;
            ri  = RrMode ? ((k + 2) % 4) : 0;
            @(negedge clk);
            chk($sformatf("cont4_ready_k%0d", k), 32'(rdy0), (k < 10) ? (32'h1 << gi) : 0);
            chk($sformatf("cont4_rsp_k%0d", k), 32'(rspv0), (k >= 2) ? (32'h1 << ri) : 0);
            if (k >= 2) chk($sformatf("cont4_sum_k%0d", k), rs0, ss[ri]);
            next_cycle();
        end

        // Requesters 1 and 3 contending, then 1 drops.
        rst0 = 1'b1; rv0 = 4'h0;
        next_cycle();
        next_cycle();
        rst0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rv0 = (k < 4) ? 4'b1010 : (k < 6) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            chk($sformatf("cont2_ready_k%0d", k), 32'(rdy0), (k < 6) ? 32'(e2[k]) : 0);
            if (k >= 2) begin
                chk($sformatf("cont2_rsp_k%0d", k), 32'(rspv0), 32'(e2[k-2]));
                chk($sformatf("cont2_sum_k%0d", k), rs0, (e2[k-2] == 4'h2) ? ss[1] : ss[3]);
            end
            next_cycle();
        end

        // LAT=3: five back-to-back issues from requesters 0,1,0,1,0.
        for (int c = 0; c < 11; c++) begin
            if (c < 5) begin
                rv3 = ptag[c];
                ra3 = pack1((ptag[c] == 4'h1) ? 0 : 1, pa[c]);
                rb3 = pack1((ptag[c] == 4'h1) ? 0 : 1, pb[c]);
            end else begin
                rv3 = 4'h0;
            end
            @(negedge clk);
            chk($sformatf("pipe_ready_c%0d", c), 32'(rdy3), (c < 5) ? 32'(ptag[c]) : 0);
            chk($sformatf("pipe_rsp_c%0d", c), 32'(rspv3),
                (c >= 5 && c < 10) ? 32'(ptag[c-5]) : 0);
            if (c >= 5 && c < 10) chk($sformatf("pipe_sum_c%0d", c), rs3, psum[c-5]);
            if (c != 9) chk($sformatf("pipe_busy_c%0d", c), 32'(busy3), (c >= 1 && c <= 8) ? 1 : 0);
            if (c == 1) begin
                chk("pipe_add_a_c1", aa3, pa[0]);
                chk("pipe_add_b_c1", ab3, pb[0]);
            end
            next_cycle();
        end

        // LAT=3: two issues, reset two cycles later, then a fresh request.
        ra3 = {32'h3FC00000, 32'h3F800000, 32'h40A00000, 32'hBAD00000};
        rb3 = {32'h40200000, 32'h40000000, 32'h40400000, 32'hBAD00000};
        for (int c = 0; c < 12; c++) begin
            logic [3:0] er;
            rst3 = (c == 3 || c == 4);
            rv3  = (c == 0) ? 4'b0100 : (c == 1) ? 4'b1000 : (c >= 3 && c <= 5) ? 4'b0010 : 4'b0000;
            er   = (c == 0) ? 4'b0100 : (c == 1) ? 4'b1000 : (c == 5) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            chk($sformatf("mid_ready_c%0d", c), 32'(rdy3), 32'(er));
            chk($sformatf("mid_rsp_c%0d", c), 32'(rspv3), (c == 10) ? 32'h2 : 0);
            if (c == 10) chk("mid_sum_c10", rs3, 32'h41000000);
            if (c == 2 || c == 6) chk($sformatf("mid_busy_c%0d", c), 32'(busy3), 1);
            if (c == 4 || c == 5) chk($sformatf("mid_busy_c%0d", c), 32'(busy3), 0);
            if (c == 6) chk("mid_add_a_c6", aa3, 32'h40A00000);
            next_cycle();
        end
        rst3 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
